// File: rtl/arbitro_paralelo_serial.sv
// Round-robin arbiter feeding one parallel-to-serial serializer, with link-sync phase.
// Optional statistics counters (beat_cnt/idle_cnt) enabled by ARB_PS_STATS_EN.
module arbitro_paralelo_serial #(
  parameter int                N_REQ     = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM  = 8'hBC,
  parameter int                SYNC_CNT  = 4,
  parameter int                MAX_BURST = 4,
  localparam int               IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    valid_out,
  output logic [DATA_W-1:0]       data_out,
  output logic [IDW-1:0]          grant_id,
  output logic                    sync_done
`ifdef ARB_PS_STATS_EN
  ,
  output logic [15:0]             beat_cnt,
  output logic [15:0]             idle_cnt
`endif
);

  localparam logic [0:0] S_SYNC   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [7:0]        sync_q, sync_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [3:0]        burst_q, burst_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDW-1:0]    gid_q, gid_d;
  logic              done_q, done_d;
  logic [15:0]       beat_q, beat_d;
  logic [15:0]       idle_q, idle_d;

  logic              others;
  logic              keep;
  logic              gnt_v;
  logic [IDW-1:0]    gnt;
  int                idx;

  // Grant pick: stay with the owner unless its burst is spent and someone waits
  always_comb begin
    others = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i != int'(last_q) && req_valid[i]) others = 1'b1;
    end
    keep  = req_valid[last_q] &&
            ((burst_q < 4'(MAX_BURST)) || !others);
    gnt_v = keep;
    gnt   = last_q;
    // Descending scan so the nearest lane after the owner wins
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!keep && req_valid[idx]) begin
        gnt_v = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  // One-hot ready only while granting in ACTIVE
  always_comb begin
    req_ready = '0;
    if (state_q == S_ACTIVE && gnt_v) req_ready[gnt] = 1'b1;
  end

  // Next-state: sync sequencing, beat capture, burst and stats bookkeeping
  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    last_d  = last_q;
    burst_d = burst_q;
    valid_d = 1'b0;
    data_d  = IDLE_SYM;
    gid_d   = gid_q;
    done_d  = done_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    if (state_q == S_SYNC) begin
      sync_d = sync_q + 8'd1;
      if (sync_q == 8'(SYNC_CNT - 1)) begin
        state_d = S_ACTIVE;
        done_d  = 1'b1;
      end
    end else if (gnt_v) begin
      valid_d = 1'b1;
      data_d  = req_data[int'(gnt)*DATA_W +: DATA_W];
      gid_d   = gnt;
      last_d  = gnt;
      if (gnt == last_q && burst_q < 4'(MAX_BURST))
        burst_d = burst_q + 4'd1;
      else
        burst_d = 4'd1;
      if (beat_q != 16'hFFFF) beat_d = beat_q + 16'd1;
    end else begin
      burst_d = 4'd0;
      if (idle_q != 16'hFFFF) idle_d = idle_q + 16'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= S_SYNC;
      sync_q  <= 8'd0;
      last_q  <= IDW'(N_REQ - 1);
      burst_q <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= IDLE_SYM;
      gid_q   <= '0;
      done_q  <= 1'b0;
      beat_q  <= 16'd0;
      idle_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign grant_id  = gid_q;
  assign sync_done = done_q;

`ifdef ARB_PS_STATS_EN
  assign beat_cnt = beat_q;
  assign idle_cnt = idle_q;
`else
  logic unused_stats;
  assign unused_stats = ^{beat_q, idle_q};
`endif

endmodule

// File: tb/tb_arbitro_paralelo_serial.sv
// Scoreboard bench for arbitro_paralelo_serial: model pushes expected
// per-cycle outputs, a monitor pops and compares after each edge.
module tb_arbitro_paralelo_serial;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SYNC = 4;
  localparam int MAXB = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [1:0]  id;
    logic        s;
    logic [15:0] bc;
    logic [15:0] ic;
  } exp_t;

  logic          clk_4f = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic [1:0]    grant_id;
  logic          sync_done;
`ifdef ARB_PS_STATS_EN
  logic [15:0]   beat_cnt;
  logic [15:0]   idle_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  int m_active, m_sync, m_owner, m_run, m_id, m_bc, m_ic;

  arbitro_paralelo_serial dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .grant_id  (grant_id),
    .sync_done (sync_done)
`ifdef ARB_PS_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .idle_cnt  (idle_cnt)
`endif
  );

  always #5 clk_4f = ~clk_4f;

  // Round-robin rule from the specification, on plain integers
  function automatic int pick(input logic [N-1:0] v, input int owner,
                              input int run);
    int others;
    int g;
    others = 0;
    g = -1;
    for (int i = 0; i < N; i++)
      if (i != owner && v[i]) others = 1;
    if (v[owner] && (run < MAXB || others == 0)) return owner;
    for (int k = 1; k <= N; k++)
      if (g < 0 && v[(owner + k) % N]) g = (owner + k) % N;
    return g;
  endfunction

  task automatic model_step();
    exp_t e;
    int g;
    logic [N-1:0] er;
    g = -1;
    if (!reset && m_active != 0) g = pick(req_valid, m_owner, m_run);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    if (!reset) begin
      checks++;
      if (req_ready !== er) begin
        errors++;
        $display("FAIL req_ready: got %b expected %b at %0t",
                 req_ready, er, $time);
      end
    end
    if (reset) begin
      m_active = 0; m_sync = 0; m_owner = N - 1; m_run = 0;
      m_id = 0; m_bc = 0; m_ic = 0;
      e.v = 1'b0; e.d = IDLE;
    end else if (m_active == 0) begin
      m_sync++;
      if (m_sync == SYNC) m_active = 1;
      e.v = 1'b0; e.d = IDLE;
    end else if (g >= 0) begin
      m_run = (g == m_owner && m_run < MAXB) ? m_run + 1 : 1;
      m_owner = g;
      m_id = g;
      if (m_bc < 16'hFFFF) m_bc++;
      e.v = 1'b1; e.d = req_data[g*W +: W];
    end else begin
      m_run = 0;
      if (m_ic < 16'hFFFF) m_ic++;
      e.v = 1'b0; e.d = IDLE;
    end
    e.id = 2'(m_id);
    e.s  = (m_active != 0);
    e.bc = 16'(m_bc);
    e.ic = 16'(m_ic);
    q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [N-1:0] v,
                      input logic [N*W-1:0] d);
    reset = rst;
    req_valid = v;
    req_data = d;
    #2;
    model_step();
    @(negedge clk_4f);
  endtask

  // Monitor: compare registered outputs just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_4f);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (valid_out !== e.v || data_out !== e.d ||
            grant_id !== e.id || sync_done !== e.s) begin
          errors++;
          $display("FAIL outputs: got v=%b d=%h id=%0d s=%b expected v=%b d=%h id=%0d s=%b at %0t",
                   valid_out, data_out, grant_id, sync_done,
                   e.v, e.d, e.id, e.s, $time);
        end
`ifdef ARB_PS_STATS_EN
        checks++;
        if (beat_cnt !== e.bc || idle_cnt !== e.ic) begin
          errors++;
          $display("FAIL stats: got beat=%0d idle=%0d expected beat=%0d idle=%0d",
                   beat_cnt, idle_cnt, e.bc, e.ic);
        end
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    m_active = 0; m_sync = 0; m_owner = N - 1; m_run = 0;
    m_id = 0; m_bc = 0; m_ic = 0;
    // T1: reset then idle sync phase
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0);
    // T2: lane0 three beats
    step(1'b0, 4'b0001, {24'h0, 8'hAB});
    step(1'b0, 4'b0001, {24'h0, 8'hCA});
    step(1'b0, 4'b0001, {24'h0, 8'h12});
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    // T3: all lanes valid
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, $urandom);
    // T5: reset mid-burst, sync with lanes still valid
    step(1'b1, 4'b1111, $urandom);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, $urandom);
    step(1'b0, '0, '0);
    // T4: lane1 alone across burst boundary
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0010, $urandom);
    // T6-like stats span: beats then idle cycles
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0100, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
    // Random traffic with occasional reset
    v = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0, v, $urandom);
    end
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    @(posedge clk_4f);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
